// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tuse/Tnew stall and bubble control plus XALU busy counter; HAZARD_PERF_EN adds stall counters
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic [4:0] A3_E,
  input  logic [1:0] Tnew_E,
  input  logic [4:0] A3_M,
  input  logic [1:0] Tnew_M,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_div_E,
  output logic       stall,
  output logic       clr,
  output logic       md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  logic             rs_hazard;
  logic             rt_hazard;
  logic             md_hazard;
  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;

  // A producer blocks a reader only if its value is ready later than the reader needs it;
  // $0 is hardwired and Tnew == 0 values are forwarded, so neither ever stalls.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    if (use_rs_D && (A1_D != 5'd0)) begin
      rs_hazard = ((A3_E == A1_D) && (Tnew_E > Tuse_rs_D)) ||
                  ((A3_M == A1_D) && (Tnew_M > Tuse_rs_D));
    end
    if (use_rt_D && (A2_D != 5'd0)) begin
      rt_hazard = ((A3_E == A2_D) && (Tnew_E > Tuse_rt_D)) ||
                  ((A3_M == A2_D) && (Tnew_M > Tuse_rt_D));
    end
    // A starting mult/div in E counts as busy already, so the D consumer waits with it.
    md_hazard = md_use_D && (md_busy || md_start_E);
  end

  assign stall   = rs_hazard || rt_hazard || md_hazard;
  assign clr     = stall;
  assign md_busy = (md_cnt_q != '0);

  // XALU countdown: a start is only accepted when idle; otherwise keep counting down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end else if (md_start_E) begin
      md_cnt_d = md_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end
  end

  // XALU busy counter register; reset drops md_busy without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] md_stall_cycles_q;
  logic [31:0] md_stall_cycles_d;

  // Saturating event counters for total stalls and the XALU-caused subset.
  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    md_stall_cycles_d = md_stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (md_hazard && (md_stall_cycles_q != 32'hFFFF_FFFF)) begin
      md_stall_cycles_d = md_stall_cycles_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q    <= 32'd0;
      md_stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      md_stall_cycles_q <= md_stall_cycles_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule
